// File: rtl/dma_word_initiator.sv
// dma_word_initiator: turns one read/write command into
// 32-bit word transactions on the DMA responder ports.
module dma_word_initiator #(
  parameter int LEN_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_handle,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_words,
  output logic             en_readrequest,
  input  logic             rdy_readrequest,
  output logic [31:0]      readrequest_addr,
  output logic [31:0]      readrequest_handle,
  output logic             en_readresponse,
  input  logic             rdy_readresponse,
  input  logic [31:0]      readresponse_data,
  output logic             en_write32,
  output logic [31:0]      write32_addr,
  output logic [31:0]      write32_handle,
  output logic [31:0]      write32_data,
  output logic [3:0]       write32_byteenable,
  output logic             rd_data_valid,
  input  logic             rd_data_ready,
  output logic [31:0]      rd_data,
  input  logic             wr_data_valid,
  output logic             wr_data_ready,
  input  logic [31:0]      wr_data,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = LEN_W + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   cur_handle;
  logic [31:0]   cur_addr;
  logic [CW-1:0] remaining;
  logic [CW-1:0] issued;
  logic [CW-1:0] received;
  logic [CW-1:0] delivered;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   fcount;

  logic [CW-1:0] outstanding;
  logic [CW:0]   credit;
  logic          in_idle;
  logic          in_read;
  logic          in_write;
  logic          push;
  logic          pop;

  assign in_idle  = (state == S_IDLE);
  assign in_read  = (state == S_READ);
  assign in_write = (state == S_WRITE);

  // Reads in flight plus buffered words never exceed the FIFO size.
  assign outstanding = issued - received;
  assign credit = {1'b0, outstanding}
                + {{(CW-AW){1'b0}}, fcount};

  assign en_readrequest = in_read && rdy_readrequest
                       && (issued < remaining)
                       && (credit < DEPTH_C);
  assign en_readresponse = in_read && rdy_readresponse
                        && (outstanding != '0);

  assign push = en_readresponse;
  assign pop  = rd_data_valid && rd_data_ready;

  assign readrequest_addr   = cur_addr;
  assign readrequest_handle = cur_handle;

  assign rd_data_valid = (fcount != '0);
  assign rd_data = rd_data_valid ? mem[rptr] : '0;

  assign wr_data_ready      = in_write;
  assign en_write32         = in_write && wr_data_valid;
  assign write32_addr       = cur_addr;
  assign write32_handle     = cur_handle;
  assign write32_data       = in_write ? wr_data : '0;
  assign write32_byteenable = 4'hf;

  assign cmd_ready = in_idle && RST;
  assign busy      = !in_idle;
  assign done      = (state == S_DONE);

  // Command sequencing, address walk and word counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      cur_handle <= '0;
      cur_addr   <= '0;
      remaining  <= '0;
      issued     <= '0;
      received   <= '0;
      delivered  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_handle <= cmd_handle;
            cur_addr   <= cmd_addr;
            remaining  <= {1'b0, cmd_words};
            issued     <= '0;
            received   <= '0;
            delivered  <= '0;
            if (cmd_words == '0)
              state <= S_DONE;
            else if (cmd_write)
              state <= S_WRITE;
            else
              state <= S_READ;
          end
        end
        S_READ: begin
          if (en_readrequest) begin
            issued   <= issued + CW'(1);
            cur_addr <= cur_addr + 32'd4;
          end
          if (push)
            received <= received + CW'(1);
          if (pop) begin
            delivered <= delivered + CW'(1);
            if (delivered + CW'(1) == remaining)
              state <= S_DONE;
          end
        end
        S_WRITE: begin
          if (en_write32) begin
            issued   <= issued + CW'(1);
            cur_addr <= cur_addr + 32'd4;
            if (issued + CW'(1) == remaining)
              state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr   <= '0;
      rptr   <= '0;
      fcount <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fcount <= fcount + (AW+1)'(1);
        2'b01:   fcount <= fcount - (AW+1)'(1);
        default: fcount <= fcount;
      endcase
    end
  end

  // Read FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wptr] <= readresponse_data;
  end

endmodule

// File: tb/tb_dma_word_initiator.sv
// tb_dma_word_initiator: directed checks of dma_word_initiator
// against a one-cycle-latency responder where word = address.
module tb_dma_word_initiator;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_handle;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_words;
  logic        en_readrequest;
  logic        rdy_readrequest;
  logic [31:0] readrequest_addr;
  logic [31:0] readrequest_handle;
  logic        en_readresponse;
  logic        rdy_readresponse;
  logic [31:0] readresponse_data;
  logic        en_write32;
  logic [31:0] write32_addr;
  logic [31:0] write32_handle;
  logic [31:0] write32_data;
  logic [3:0]  write32_byteenable;
  logic        rd_data_valid;
  logic        rd_data_ready;
  logic [31:0] rd_data;
  logic        wr_data_valid;
  logic        wr_data_ready;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dma_word_initiator #(.LEN_W(16), .DEPTH(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_handle(cmd_handle),
    .cmd_addr(cmd_addr),
    .cmd_words(cmd_words),
    .en_readrequest(en_readrequest),
    .rdy_readrequest(rdy_readrequest),
    .readrequest_addr(readrequest_addr),
    .readrequest_handle(readrequest_handle),
    .en_readresponse(en_readresponse),
    .rdy_readresponse(rdy_readresponse),
    .readresponse_data(readresponse_data),
    .en_write32(en_write32),
    .write32_addr(write32_addr),
    .write32_handle(write32_handle),
    .write32_data(write32_data),
    .write32_byteenable(write32_byteenable),
    .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready),
    .rd_data(rd_data),
    .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready),
    .wr_data(wr_data),
    .busy(busy),
    .done(done)
  );

  // Responder: each accepted request answers one cycle later
  logic [31:0] rq [16];
  logic [3:0]  rh;
  logic [3:0]  rt;

  assign rdy_readresponse  = (rh != rt);
  assign readresponse_data = rq[rh];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rh <= '0;
      rt <= '0;
    end else begin
      if (en_readrequest) begin
        rq[rt] <= readrequest_addr;
        rt <= rt + 4'd1;
      end
      if (en_readresponse)
        rh <= rh + 4'd1;
    end
  end

  // Transaction logs
  logic [31:0] req_a [64];
  logic [31:0] req_h [64];
  logic [31:0] rd_l  [64];
  logic [31:0] wr_a  [64];
  logic [31:0] wr_d  [64];
  logic [31:0] wr_h  [64];
  logic [3:0]  wr_be [64];
  int nreq = 0;
  int nrd = 0;
  int nwr = 0;
  int done_cnt = 0;

  always @(posedge CLK) begin
    if (en_readrequest) begin
      req_a[nreq[5:0]] <= readrequest_addr;
      req_h[nreq[5:0]] <= readrequest_handle;
      nreq <= nreq + 1;
    end
    if (rd_data_valid && rd_data_ready) begin
      rd_l[nrd[5:0]] <= rd_data;
      nrd <= nrd + 1;
    end
    if (en_write32) begin
      wr_a[nwr[5:0]]  <= write32_addr;
      wr_d[nwr[5:0]]  <= write32_data;
      wr_h[nwr[5:0]]  <= write32_handle;
      wr_be[nwr[5:0]] <= write32_byteenable;
      nwr <= nwr + 1;
    end
    if (done)
      done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic w,
                        input logic [31:0] h,
                        input logic [31:0] a,
                        input logic [15:0] n);
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_handle = h;
    cmd_addr   = a;
    cmd_words  = n;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    int k;
    k = 0;
    while (!done && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  int b_req;
  int b_rd;
  int b_wr;
  int b_dn;
  int k;

  initial begin
    RST = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_handle = '0;
    cmd_addr = '0;
    cmd_words = '0;
    rdy_readrequest = 1'b1;
    rd_data_ready = 1'b0;
    wr_data_valid = 1'b0;
    wr_data = '0;

    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_enrq", 32'(en_readrequest), 32'd0);
    chk("rst_enwr", 32'(en_write32), 32'd0);
    chk("rst_rdv", 32'(rd_data_valid), 32'd0);
    chk("rst_wrdy", 32'(wr_data_ready), 32'd0);
    chk("rst_rqaddr", readrequest_addr, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Test 1: read 4 words at 0x100, handle 5
    rd_data_ready = 1'b1;
    b_req = nreq; b_rd = nrd; b_dn = done_cnt;
    do_cmd(1'b0, 32'd5, 32'h100, 16'd4);
    chk("t1_first_req", 32'(en_readrequest), 32'd1);
    chk("t1_req_addr0", readrequest_addr, 32'h100);
    chk("t1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    @(negedge CLK);
    chk("t1_rdv_early", 32'(rd_data_valid), 32'd0);
    @(negedge CLK);
    chk("t1_rdv_lat", 32'(rd_data_valid), 32'd1);
    chk("t1_rd_first", rd_data, 32'h100);
    wait_pulse("t1_done");
    chk("t1_busy_in_done", 32'(busy), 32'd1);
    @(negedge CLK);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_done_low", 32'(done), 32'd0);
    chk("t1_nreq", nreq - b_req, 32'd4);
    chk("t1_nrd", nrd - b_rd, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_req_a", req_a[b_req+i], 32'h100 + 4*i);
      chk("t1_rd", rd_l[b_rd+i], 32'h100 + 4*i);
    end
    chk("t1_req_h", req_h[b_req], 32'd5);
    repeat (3) @(negedge CLK);
    chk("t1_done_once", done_cnt - b_dn, 32'd1);

    // Test 2: 8-word read with the consumer stalled
    rd_data_ready = 1'b0;
    b_req = nreq; b_rd = nrd;
    do_cmd(1'b0, 32'd7, 32'h400, 16'd8);
    repeat (20) @(negedge CLK);
    chk("t2_stall_nreq", nreq - b_req, 32'd4);
    chk("t2_stall_enrq", 32'(en_readrequest), 32'd0);
    chk("t2_stall_enrs", 32'(en_readresponse), 32'd0);
    chk("t2_stall_rdv", 32'(rd_data_valid), 32'd1);
    chk("t2_stall_head", rd_data, 32'h400);
    rd_data_ready = 1'b1;
    wait_pulse("t2_done");
    chk("t2_nreq", nreq - b_req, 32'd8);
    chk("t2_nrd", nrd - b_rd, 32'd8);
    for (int i = 0; i < 8; i++)
      chk("t2_rd", rd_l[b_rd+i], 32'h400 + 4*i);
    @(negedge CLK);

    // Test 3: 3-word write with gaps between words
    b_wr = nwr; b_req = nreq;
    do_cmd(1'b1, 32'd9, 32'h200, 16'd3);
    chk("t3_wrdy", 32'(wr_data_ready), 32'd1);
    chk("t3_enwr_idle", 32'(en_write32), 32'd0);
    for (int i = 0; i < 3; i++) begin
      wr_data_valid = 1'b1;
      wr_data = 32'hA + 32'(i);
      @(negedge CLK);
      wr_data_valid = 1'b0;
      chk("t3_done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
      if (i < 2) repeat (2) @(negedge CLK);
    end
    chk("t3_nwr", nwr - b_wr, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_wr_a", wr_a[b_wr+i], 32'h200 + 4*i);
      chk("t3_wr_d", wr_d[b_wr+i], 32'hA + 32'(i));
      chk("t3_wr_be", 32'(wr_be[b_wr+i]), 32'hf);
    end
    chk("t3_wr_h", wr_h[b_wr], 32'd9);
    chk("t3_no_reads", nreq - b_req, 32'd0);
    @(negedge CLK);

    // Test 4: address wrap
    b_req = nreq; b_rd = nrd;
    do_cmd(1'b0, 32'd1, 32'hFFFF_FFFC, 16'd2);
    wait_pulse("t4_done");
    chk("t4_nreq", nreq - b_req, 32'd2);
    chk("t4_a0", req_a[b_req], 32'hFFFF_FFFC);
    chk("t4_a1", req_a[b_req+1], 32'h0);
    chk("t4_rd1", rd_l[b_rd+1], 32'h0);
    @(negedge CLK);

    // Test 5: zero-length command
    b_req = nreq; b_wr = nwr; b_dn = done_cnt;
    do_cmd(1'b0, 32'd2, 32'h300, 16'd0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_enrq", 32'(en_readrequest), 32'd0);
    chk("t5_enrs", 32'(en_readresponse), 32'd0);
    @(negedge CLK);
    chk("t5_done_low", 32'(done), 32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5_nact", (nreq - b_req) + (nwr - b_wr), 32'd0);
    chk("t5_done_once", done_cnt - b_dn, 32'd1);

    // Test 6: reset mid-read, then a fresh 1-word read
    b_rd = nrd; b_dn = done_cnt;
    do_cmd(1'b0, 32'd3, 32'h500, 16'd4);
    k = 0;
    while (nrd - b_rd < 2 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("t6_two_words", nrd - b_rd, 32'd2);
    RST = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_enrq", 32'(en_readrequest), 32'd0);
    chk("t6_rst_enrs", 32'(en_readresponse), 32'd0);
    chk("t6_rst_rdv", 32'(rd_data_valid), 32'd0);
    chk("t6_rst_rd", rd_data, 32'd0);
    chk("t6_rst_addr", readrequest_addr, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_no_done", done_cnt - b_dn, 32'd0);
    b_rd = nrd;
    do_cmd(1'b0, 32'd4, 32'h600, 16'd1);
    wait_pulse("t6_done");
    chk("t6_nrd", nrd - b_rd, 32'd1);
    chk("t6_rd", rd_l[b_rd], 32'h600);
    @(negedge CLK);
    chk("t6_done_once", done_cnt - b_dn, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
